// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the Execute stage and the
// iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic                  flush_i;
  logic [2:0]            op_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output start_i,
    output flush_i,
    output op_i,
    output a_i,
    output b_i,
    input  busy_o,
    input  done_o,
    input  result_o
  );

  modport slave (
    input  start_i,
    input  flush_i,
    input  op_i,
    input  a_i,
    input  b_i,
    output busy_o,
    output done_o,
    output result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a
// shared shift/add-subtract datapath, all eight M-extension ops.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  muldiv_unit_if.slave  bus
);

  localparam int W = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(W) + 1;
  localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [2:0]           opQ;
  logic [W-1:0]         aQ;
  logic [W-1:0]         bQ;
  logic [W-1:0]         accHi;
  logic [W-1:0]         accLo;
  logic [W-1:0]         addend;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 negQ;
  logic [W-1:0]         resultQ;

  logic         isDiv;
  logic         aSigned;
  logic         bSigned;
  logic         aNeg;
  logic         bNeg;
  logic [W-1:0] aMag;
  logic [W-1:0] bMag;
  logic         divZero;
  logic         overflow;
  logic         bypass;
  logic         negRes;
  logic [W-1:0] bypassRes;

  logic [W:0]     sum;
  logic [W:0]     hiSel;
  logic [W:0]     shifted;
  logic [W+1:0]   diff;
  logic [W-1:0]   hiN;
  logic [W-1:0]   loN;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prodS;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   finalRes;
  logic           lastIter;

  // Operand decode from the latched funct3
  always_comb begin
    isDiv    = opQ[2];
    aSigned  = isDiv ? ~opQ[0] : (opQ[1:0] != 2'b11);
    bSigned  = isDiv ? ~opQ[0] : ~opQ[1];
    aNeg     = aSigned & aQ[W-1];
    bNeg     = bSigned & bQ[W-1];
    aMag     = aNeg ? ('0 - aQ) : aQ;
    bMag     = bNeg ? ('0 - bQ) : bQ;
    divZero  = isDiv & (bQ == '0);
    overflow = isDiv & ~opQ[0] & (aQ == MinVal) & (&bQ);
    bypass   = divZero | overflow;
    negRes   = (isDiv & opQ[1]) ? aNeg : (aNeg ^ bNeg);
    bypassRes = '0;
    unique case (1'b1)
      divZero & ~opQ[1]:  bypassRes = '1;
      divZero & opQ[1]:   bypassRes = aQ;
      overflow & ~opQ[1]: bypassRes = MinVal;
      default:            bypassRes = '0;
    endcase
  end

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    sum     = {1'b0, accHi} + {1'b0, addend};
    hiSel   = accLo[0] ? sum : {1'b0, accHi};
    shifted = {accHi, accLo[W-1]};
    diff    = {1'b0, shifted} - {2'b00, addend};
    hiN     = hiSel[W:1];
    loN     = {hiSel[0], accLo[W-1:1]};
    if (isDiv) begin
      if (!diff[W+1]) begin
        hiN = diff[W-1:0];
        loN = {accLo[W-2:0], 1'b1};
      end else begin
        hiN = shifted[W-1:0];
        loN = {accLo[W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod     = {hiN, loN};
    prodS    = negQ ? ('0 - prod) : prod;
    quo      = negQ ? ('0 - loN) : loN;
    rem      = negQ ? ('0 - hiN) : hiN;
    finalRes = '0;
    unique case (1'b1)
      ~isDiv & (opQ[1:0] == 2'b00): finalRes = prodS[W-1:0];
      ~isDiv & (opQ[1:0] != 2'b00): finalRes = prodS[2*W-1:W];
      isDiv & ~opQ[1]:              finalRes = quo;
      default:                      finalRes = rem;
    endcase
  end

  assign lastIter = (cnt == CNT_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) stateNext = PREP;
      end
      PREP: begin
        if (bus.flush_i)  stateNext = IDLE;
        else if (bypass)  stateNext = DONE;
        else              stateNext = CALC;
      end
      CALC: begin
        if (bus.flush_i)   stateNext = IDLE;
        else if (lastIter) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opQ     <= '0;
      aQ      <= '0;
      bQ      <= '0;
      accHi   <= '0;
      accLo   <= '0;
      addend  <= '0;
      cnt     <= '0;
      negQ    <= 1'b0;
      resultQ <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            opQ <= bus.op_i;
            aQ  <= bus.a_i;
            bQ  <= bus.b_i;
          end
        end
        PREP: begin
          negQ   <= negRes;
          cnt    <= CNT_WIDTH'(W);
          accHi  <= '0;
          accLo  <= isDiv ? aMag : bMag;
          addend <= isDiv ? bMag : aMag;
          if (!bus.flush_i && bypass) resultQ <= bypassRes;
        end
        CALC: begin
          if (!bus.flush_i) begin
            accHi <= hiN;
            accLo <= loN;
            cnt   <= cnt - CNT_WIDTH'(1);
            if (lastIter) resultQ <= finalRes;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = (state == PREP) || (state == CALC);
  assign bus.done_o   = (state == DONE);
  assign bus.result_o = resultQ;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at W=32.
// Cycle n is observed 1 time unit after the n-th edge following start.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  muldiv_unit_if #(.DATA_WIDTH(32)) bus();

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.op_i    = 3'b011;
    bus.a_i     = 32'hDEAD_BEEF;
    bus.b_i     = 32'h1234_5678;
  endtask

  // Observes one operation; optionally pulses start_i in cycle pulseCyc
  task automatic waitDone(input  int pulseCyc,
                          output int doneCyc,
                          output int busyCnt,
                          output int overlap,
                          output logic [31:0] res);
    doneCyc = -1;
    busyCnt = 0;
    overlap = 0;
    res     = '0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.busy_o) busyCnt++;
      if (bus.busy_o && bus.done_o) overlap++;
      if (bus.done_o && doneCyc < 0) begin
        doneCyc = c;
        res     = bus.result_o;
      end
      if (c == pulseCyc) begin
        bus.start_i = 1'b1;
        bus.op_i    = 3'b000;
        bus.a_i     = 32'd3;
        bus.b_i     = 32'd3;
      end
      step();
      bus.start_i = 1'b0;
      if (doneCyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.start_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'b000;
    bus.a_i     = 32'd5;
    bus.b_i     = 32'd6;
    step();
    step();
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
    end
    checks++;
    if (bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", bus.done_o);
    end
    checks++;
    if (bus.result_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 00000000", bus.result_o);
    end
    bus.start_i = 1'b0;
    rst         = 1'b0;
    step();
  endtask

  task automatic test_mul();
    logic [2:0]  op[4];
    logic [31:0] a[4];
    logic [31:0] b[4];
    logic [31:0] e[4];
    int dc, bc, ov;
    logic [31:0] r;
    op[0] = 3'b000; a[0] = 32'd7;        b[0] = 32'hFFFF_FFFD; e[0] = 32'hFFFF_FFEB;
    op[1] = 3'b001; a[1] = 32'h8000_0000; b[1] = 32'h8000_0000; e[1] = 32'h4000_0000;
    op[2] = 3'b011; a[2] = 32'hFFFF_FFFF; b[2] = 32'hFFFF_FFFF; e[2] = 32'hFFFF_FFFE;
    op[3] = 3'b010; a[3] = 32'hFFFF_FFFF; b[3] = 32'hFFFF_FFFF; e[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      doStart(op[i], a[i], b[i]);
      waitDone(0, dc, bc, ov, r);
      checks++;
      if (dc !== 34) begin
        errors++;
        $display("FAIL mul%0d_done_cycle: got %0d expected 34", i, dc);
      end
      checks++;
      if (r !== e[i]) begin
        errors++;
        $display("FAIL mul%0d_result: got %h expected %h", i, r, e[i]);
      end
      checks++;
      if (bc !== 33 || ov !== 0) begin
        errors++;
        $display("FAIL mul%0d_busy: got %0d busy/%0d overlap expected 33/0",
                 i, bc, ov);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  op[4];
    logic [31:0] a[4];
    logic [31:0] b[4];
    logic [31:0] e[4];
    int dc, bc, ov;
    logic [31:0] r;
    op[0] = 3'b100; a[0] = 32'hFFFF_FFF9; b[0] = 32'd2; e[0] = 32'hFFFF_FFFD;
    op[1] = 3'b110; a[1] = 32'hFFFF_FFF9; b[1] = 32'd2; e[1] = 32'hFFFF_FFFF;
    op[2] = 3'b101; a[2] = 32'd100;       b[2] = 32'd7; e[2] = 32'd14;
    op[3] = 3'b111; a[3] = 32'd100;       b[3] = 32'd7; e[3] = 32'd2;
    for (int i = 0; i < 4; i++) begin
      doStart(op[i], a[i], b[i]);
      waitDone(0, dc, bc, ov, r);
      checks++;
      if (dc !== 34) begin
        errors++;
        $display("FAIL div%0d_done_cycle: got %0d expected 34", i, dc);
      end
      checks++;
      if (r !== e[i]) begin
        errors++;
        $display("FAIL div%0d_result: got %h expected %h", i, r, e[i]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [2:0]  op[6];
    logic [31:0] a[6];
    logic [31:0] b[6];
    logic [31:0] e[6];
    int dc, bc, ov;
    logic [31:0] r;
    op[0] = 3'b101; a[0] = 32'd5;         b[0] = 32'd0;         e[0] = 32'hFFFF_FFFF;
    op[1] = 3'b110; a[1] = 32'd5;         b[1] = 32'd0;         e[1] = 32'd5;
    op[2] = 3'b100; a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF; e[2] = 32'h8000_0000;
    op[3] = 3'b110; a[3] = 32'h8000_0000; b[3] = 32'hFFFF_FFFF; e[3] = 32'h0;
    op[4] = 3'b100; a[4] = 32'hFFFF_FFF0; b[4] = 32'd0;         e[4] = 32'hFFFF_FFFF;
    op[5] = 3'b111; a[5] = 32'hFFFF_FFF0; b[5] = 32'd0;         e[5] = 32'hFFFF_FFF0;
    for (int i = 0; i < 6; i++) begin
      doStart(op[i], a[i], b[i]);
      waitDone(0, dc, bc, ov, r);
      checks++;
      if (dc !== 2) begin
        errors++;
        $display("FAIL bypass%0d_done_cycle: got %0d expected 2", i, dc);
      end
      checks++;
      if (r !== e[i]) begin
        errors++;
        $display("FAIL bypass%0d_result: got %h expected %h", i, r, e[i]);
      end
    end
  endtask

  task automatic test_flush();
    int dc, bc, ov;
    int sawDone, sawBusy;
    logic [31:0] r;
    doStart(3'b111, 32'd100, 32'd7);
    waitDone(0, dc, bc, ov, r);
    doStart(3'b101, 32'd100, 32'd7);
    repeat (9) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_c11: got %b expected 0", bus.busy_o);
    end
    sawDone = 0;
    sawBusy = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done_o) sawDone++;
      if (bus.busy_o) sawBusy++;
      step();
    end
    checks++;
    if (sawDone !== 0 || sawBusy !== 0) begin
      errors++;
      $display("FAIL flush_quiet: got %0d done/%0d busy expected 0/0",
               sawDone, sawBusy);
    end
    checks++;
    if (bus.result_o !== 32'd2) begin
      errors++;
      $display("FAIL flush_result_kept: got %h expected 00000002",
               bus.result_o);
    end
    bus.flush_i = 1'b1;
    bus.op_i    = 3'b000;
    bus.a_i     = 32'd9;
    bus.b_i     = 32'd9;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_beats_start: got busy %b done %b expected 0 0",
               bus.busy_o, bus.done_o);
    end
    step();
  endtask

  task automatic test_ignored_start();
    int dc, bc, ov;
    logic [31:0] r;
    doStart(3'b101, 32'd100, 32'd7);
    waitDone(5, dc, bc, ov, r);
    checks++;
    if (dc !== 34 || r !== 32'd14) begin
      errors++;
      $display("FAIL start_mid_op: got cycle %0d result %h expected 34 0000000e",
               dc, r);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL start_mid_op_idle: got busy %b expected 0", bus.busy_o);
    end
    doStart(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(34, dc, bc, ov, r);
    checks++;
    if (dc !== 34 || r !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL start_in_done_op: got cycle %0d result %h expected 34 fffffffe",
               dc, r);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got busy %b expected 0", bus.busy_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int dc, bc, ov;
    logic [31:0] r;
    doStart(3'b000, 32'h1234, 32'h5678);
    repeat (11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got busy %b done %b expected 0 0",
               bus.busy_o, bus.done_o);
    end
    checks++;
    if (bus.result_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_result: got %h expected 00000000", bus.result_o);
    end
    doStart(3'b000, 32'd3, 32'd4);
    waitDone(0, dc, bc, ov, r);
    checks++;
    if (dc !== 34) begin
      errors++;
      $display("FAIL rst_then_mul_cycle: got %0d expected 34", dc);
    end
    checks++;
    if (r !== 32'd12) begin
      errors++;
      $display("FAIL rst_then_mul_result: got %h expected 0000000c", r);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'b000;
    bus.a_i     = '0;
    bus.b_i     = '0;
    #1;
    test_reset();
    test_mul();
    test_div();
    test_bypass();
    test_flush();
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
